// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback scheduler.
//   WB_* constants  - source encodings, identical to the writeback mux select
//   WB_RD_W         - width of the rd field held in a queue entry
//   wb_entry_t      - one queue entry {src, rd, data, rdy}
package wb_pkg;

  localparam logic [1:0] WB_LINK = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_MEM  = 2'd2;
  localparam logic [1:0] WB_ZERO = 2'd3;

  // Entries carry rd at this width; the top casts to/from its REG_AW.
  localparam int unsigned WB_RD_W = 5;

  typedef struct packed {
    logic [1:0]         src;
    logic [WB_RD_W-1:0] rd;
    logic [31:0]        data;
    logic               rdy;
  } wb_entry_t;

endpackage

// File: rtl/wb_sched_if.sv
// wb_sched_if: issue, load-response, flush and writeback signals of wb_sched.
//   master - the core side (drives issue/response/flush, observes writeback)
//   slave  - the scheduler itself
interface wb_sched_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned REG_AW = 5
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              iss_valid;
  logic              iss_ready;
  logic [1:0]        iss_src;
  logic [REG_AW-1:0] iss_rd;
  logic [31:0]       iss_nextPC;
  logic [31:0]       iss_alu;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [1:0]        wb_src;
  logic [31:0]       wb_nextPC;
  logic [31:0]       wb_alu;
  logic [31:0]       wb_mem;
  logic [CntW-1:0]   loads_pending;
  logic              err_unexp;

  modport master (
    output flush, iss_valid, iss_src, iss_rd, iss_nextPC, iss_alu, mem_rsp_valid, mem_rsp_data,
    input  iss_ready, wb_we, wb_rd, wb_src, wb_nextPC, wb_alu, wb_mem, loads_pending, err_unexp
  );

  modport slave (
    input  flush, iss_valid, iss_src, iss_rd, iss_nextPC, iss_alu, mem_rsp_valid, mem_rsp_data,
    output iss_ready, wb_we, wb_rd, wb_src, wb_nextPC, wb_alu, wb_mem, loads_pending, err_unexp
  );

endinterface

// File: rtl/wb_queue.sv
// wb_queue: DEPTH-entry in-order result queue.
//   clr_i                 - empty the queue (takes priority over everything else)
//   push_i/push_entry_i   - write an entry at the tail
//   pop_i                 - drop the head entry
//   fill_i/fill_data_i    - complete the oldest not-ready entry (load return)
//   head_o, empty_o, full_o
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        push_i,
  input  wb_entry_t   push_entry_i,
  input  logic        pop_i,
  input  logic        fill_i,
  input  logic [31:0] fill_data_i,
  output wb_entry_t   head_o,
  output logic        empty_o,
  output logic        full_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t       ent_q [DEPTH];
  wb_entry_t       ent_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Load pointer: oldest occupied entry still waiting for data. Loads return
  // in issue order, so the first not-ready entry from the head is the target.
  logic [PtrW-1:0] ld_ptr, idx;
  logic            ld_found;

  always_comb begin
    ld_ptr   = head_q;
    ld_found = 1'b0;
    idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (!ld_found && (CntW'(i) < cnt_q) && !ent_q[idx].rdy) begin
        ld_ptr   = idx;
        ld_found = 1'b1;
      end
    end
  end

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      // A fill never hits the popped head (head must be ready to pop) nor the
      // pushed slot (it was free), so all three may coexist.
      if (fill_i && ld_found) begin
        ent_d[ld_ptr].data = fill_data_i;
        ent_d[ld_ptr].rdy  = 1'b1;
      end
      if (push_i) begin
        ent_d[tail_q] = push_entry_i;
        tail_d        = tail_q + 1'b1;
      end
      if (pop_i) begin
        head_d = head_q + 1'b1;
      end
      cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = ent_q[head_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(DEPTH));

endmodule

// File: rtl/wb_sched.sv
// wb_sched: in-order writeback scheduler for the single register-file write port.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - issue / load response / flush inputs, registered writeback outputs,
//              loads_pending count and sticky err_unexp
module wb_sched
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned REG_AW = 5
) (
  input  logic     clk,
  input  logic     rst,
  wb_sched_if.slave bus
);
  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  // Drain may stack across back-to-back flushes, so give it headroom.
  localparam int unsigned DrainW = CntW + 4;

  logic        q_empty, q_full;
  wb_entry_t   head, push_entry;
  logic        acc_iss, mem_iss, pop;
  logic        rsp_drain, rsp_load, rsp_unexp;

  logic [CntW-1:0]   pend_q, pend_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [1:0]        src_q, src_d;
  logic [31:0]       npc_q, npc_d, alu_q, alu_d, mem_q, mem_d;

  assign acc_iss = bus.iss_valid && !q_full;
  assign mem_iss = acc_iss && (bus.iss_src == WB_MEM);

  // Responses go first to the drain of flushed loads, then to live loads.
  assign rsp_drain = bus.mem_rsp_valid && (drain_q != '0);
  assign rsp_load  = bus.mem_rsp_valid && (drain_q == '0) && (pend_q != '0);
  assign rsp_unexp = bus.mem_rsp_valid && (drain_q == '0) && (pend_q == '0);

  assign pop = !q_empty && head.rdy && !bus.flush;

  always_comb begin
    push_entry     = '0;
    push_entry.src = bus.iss_src;
    push_entry.rd  = WB_RD_W'(bus.iss_rd);
    unique case (bus.iss_src)
      WB_LINK: begin
        push_entry.data = bus.iss_nextPC;
        push_entry.rdy  = 1'b1;
      end
      WB_ALU: begin
        push_entry.data = bus.iss_alu;
        push_entry.rdy  = 1'b1;
      end
      WB_MEM: begin
        push_entry.rdy  = 1'b0;
      end
      default: begin
        push_entry.rdy  = 1'b1;
      end
    endcase
  end

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (bus.flush),
    .push_i       (acc_iss && !bus.flush),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .fill_i       (rsp_load && !bus.flush),
    .fill_data_i  (bus.mem_rsp_data),
    .head_o       (head),
    .empty_o      (q_empty),
    .full_o       (q_full)
  );

  always_comb begin
    err_d = err_q | rsp_unexp;
    if (bus.flush) begin
      // Every load still out (including one issued now) must be swallowed.
      pend_d  = '0;
      drain_d = drain_q - DrainW'(rsp_drain) + DrainW'(pend_q) + DrainW'(mem_iss)
                - DrainW'(rsp_load);
    end else begin
      pend_d  = pend_q + CntW'(mem_iss) - CntW'(rsp_load);
      drain_d = drain_q - DrainW'(rsp_drain);
    end
  end

  always_comb begin
    we_d  = 1'b0;
    rd_d  = rd_q;
    src_d = src_q;
    npc_d = npc_q;
    alu_d = alu_q;
    mem_d = mem_q;
    if (pop) begin
      we_d  = (head.src != WB_ZERO) && (head.rd != '0);
      rd_d  = REG_AW'(head.rd);
      src_d = head.src;
      npc_d = (head.src == WB_LINK) ? head.data : 32'd0;
      alu_d = (head.src == WB_ALU)  ? head.data : 32'd0;
      mem_d = (head.src == WB_MEM)  ? head.data : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      src_q   <= '0;
      npc_q   <= '0;
      alu_q   <= '0;
      mem_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      src_q   <= src_d;
      npc_q   <= npc_d;
      alu_q   <= alu_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.iss_ready     = !q_full;
  assign bus.wb_we         = we_q;
  assign bus.wb_rd         = rd_q;
  assign bus.wb_src        = src_q;
  assign bus.wb_nextPC     = npc_q;
  assign bus.wb_alu        = alu_q;
  assign bus.wb_mem        = mem_q;
  assign bus.loads_pending = pend_q;
  assign bus.err_unexp     = err_q;

endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: directed scenarios plus randomized traffic against a queue-based
// reference model of the writeback scheduler.
module tb_wb_sched;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;
  int   n_print = 0;

  wb_sched_if #(.DEPTH(DEPTH), .REG_AW(5)) bus ();

  wb_sched #(.DEPTH(DEPTH), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          rdy;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_drain = 0;
  bit          m_err   = 0;
  logic        e_we    = 0;
  logic [4:0]  e_rd    = 0;
  logic [1:0]  e_src   = 0;
  logic [31:0] e_npc   = 0;
  logic [31:0] e_alu   = 0;
  logic [31:0] e_mem   = 0;

  int     mp_pend;
  bit     mp_acc, mp_load, mp_pop, mp_done;
  m_ent_t mp_h, mp_n;

  function automatic int m_pending();
    int c = 0;
    foreach (mq[i]) if (!mq[i].rdy) c++;
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_drain = 0;
      m_err   = 0;
      e_we = 0; e_rd = 0; e_src = 0; e_npc = 0; e_alu = 0; e_mem = 0;
    end else begin
      mp_pend = m_pending();
      mp_acc  = bus.iss_valid && (mq.size() < DEPTH);
      mp_pop  = !bus.flush && (mq.size() > 0) && mq[0].rdy;
      mp_load = 0;
      if (bus.mem_rsp_valid) begin
        if (m_drain > 0)      m_drain--;
        else if (mp_pend > 0) mp_load = 1;
        else                  m_err = 1;
      end
      e_we = 0;
      if (bus.flush) begin
        m_drain += mp_pend + ((mp_acc && bus.iss_src == 2'd2) ? 1 : 0) - (mp_load ? 1 : 0);
        mq.delete();
      end else begin
        if (mp_pop) begin
          mp_h  = mq.pop_front();
          e_we  = (mp_h.src != 2'd3) && (mp_h.rd != 0);
          e_rd  = mp_h.rd;
          e_src = mp_h.src;
          e_npc = (mp_h.src == 2'd0) ? mp_h.data : 32'd0;
          e_alu = (mp_h.src == 2'd1) ? mp_h.data : 32'd0;
          e_mem = (mp_h.src == 2'd2) ? mp_h.data : 32'd0;
        end
        if (mp_load) begin
          mp_done = 0;
          for (int i = 0; i < mq.size(); i++) begin
            if (!mp_done && !mq[i].rdy) begin
              mq[i].data = bus.mem_rsp_data;
              mq[i].rdy  = 1;
              mp_done    = 1;
            end
          end
        end
        if (mp_acc) begin
          mp_n.src  = bus.iss_src;
          mp_n.rd   = bus.iss_rd;
          mp_n.rdy  = (bus.iss_src != 2'd2);
          case (bus.iss_src)
            2'd0:    mp_n.data = bus.iss_nextPC;
            2'd1:    mp_n.data = bus.iss_alu;
            default: mp_n.data = 32'd0;
          endcase
          mq.push_back(mp_n);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      n_run++;
      if (bus.iss_ready !== (mq.size() < DEPTH) || bus.wb_we !== e_we || bus.wb_rd !== e_rd ||
          bus.wb_src !== e_src || bus.wb_nextPC !== e_npc || bus.wb_alu !== e_alu ||
          bus.wb_mem !== e_mem || bus.loads_pending !== 3'(m_pending()) ||
          bus.err_unexp !== m_err) begin
        n_fail++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL cycle_compare t=%0t got rdy=%0b we=%0b rd=%0d src=%0d npc=%h alu=%h mem=%h pend=%0d err=%0b; expected rdy=%0b we=%0b rd=%0d src=%0d npc=%h alu=%h mem=%h pend=%0d err=%0b",
                   $time, bus.iss_ready, bus.wb_we, bus.wb_rd, bus.wb_src, bus.wb_nextPC,
                   bus.wb_alu, bus.wb_mem, bus.loads_pending, bus.err_unexp,
                   (mq.size() < DEPTH), e_we, e_rd, e_src, e_npc, e_alu, e_mem,
                   m_pending(), m_err);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] s, input logic [4:0] rd, input logic [31:0] v);
    bus.iss_valid  = 1'b1;
    bus.iss_src    = s;
    bus.iss_rd     = rd;
    bus.iss_alu    = v;
    bus.iss_nextPC = v ^ 32'hFFFF_0000;
    tick();
    bus.iss_valid  = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = d;
    tick();
    bus.mem_rsp_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst               = 1'b1;
    bus.flush         = 1'b0;
    bus.iss_valid     = 1'b0;
    bus.iss_src       = 2'd0;
    bus.iss_rd        = 5'd0;
    bus.iss_nextPC    = 32'd0;
    bus.iss_alu       = 32'd0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'd0;
    tick();
    check("reset_ready", bus.iss_ready, 1);
    check("reset_we", bus.wb_we, 0);
    check("reset_pend", bus.loads_pending, 0);
    check("reset_err", bus.err_unexp, 0);
    tick();
    rst = 1'b0;
    tick();

    // ALU into empty queue: two-edge latency, one-cycle write
    issue(2'd1, 5'd5, 32'h1234);
    check("alu_no_early_we", bus.wb_we, 0);
    tick();
    check("alu_we", bus.wb_we, 1);
    check("alu_src", bus.wb_src, 1);
    check("alu_rd", bus.wb_rd, 5);
    check("alu_data", bus.wb_alu, 32'h1234);
    check("alu_npc_zero", bus.wb_nextPC, 0);
    tick();
    check("alu_we_drop", bus.wb_we, 0);
    check("alu_rd_hold", bus.wb_rd, 5);

    // load blocks a younger ALU
    issue(2'd2, 5'd3, 32'd0);
    issue(2'd1, 5'd4, 32'h44);
    tick();
    check("ld_blocked_we", bus.wb_we, 0);
    check("ld_pending", bus.loads_pending, 1);
    respond(32'hBEEF);
    check("ld_no_bypass", bus.wb_we, 0);
    check("ld_pending_done", bus.loads_pending, 0);
    tick();
    check("ld_we", bus.wb_we, 1);
    check("ld_rd", bus.wb_rd, 3);
    check("ld_src", bus.wb_src, 2);
    check("ld_mem", bus.wb_mem, 32'hBEEF);
    check("ld_alu_zero", bus.wb_alu, 0);
    tick();
    check("ld_next_we", bus.wb_we, 1);
    check("ld_next_rd", bus.wb_rd, 4);
    check("ld_next_alu", bus.wb_alu, 32'h44);
    check("ld_next_mem_zero", bus.wb_mem, 0);
    tick();

    // fill the queue behind a load
    issue(2'd2, 5'd7, 32'd0);
    issue(2'd1, 5'd8, 32'd1);
    issue(2'd1, 5'd9, 32'd2);
    issue(2'd1, 5'd10, 32'd3);
    check("full_ready", bus.iss_ready, 0);
    respond(32'h77);
    check("full_ready_after_fill", bus.iss_ready, 0);
    tick();
    check("full_ready_after_pop", bus.iss_ready, 1);
    check("full_pop_rd", bus.wb_rd, 7);
    check("full_pop_mem", bus.wb_mem, 32'h77);
    tick();
    check("full_second_rd", bus.wb_rd, 8);
    repeat (3) tick();

    // ZERO and rd=0 never write
    issue(2'd3, 5'd9, 32'hAAAA);
    issue(2'd1, 5'd0, 32'h55);
    check("zero_we", bus.wb_we, 0);
    check("zero_src", bus.wb_src, 3);
    check("zero_rd", bus.wb_rd, 9);
    check("zero_alu", bus.wb_alu, 0);
    tick();
    check("rd0_we", bus.wb_we, 0);
    check("rd0_src", bus.wb_src, 1);
    check("rd0_alu", bus.wb_alu, 32'h55);
    tick();

    // flush with two loads out
    issue(2'd2, 5'd1, 32'd0);
    issue(2'd2, 5'd2, 32'd0);
    check("flush_pre_pend", bus.loads_pending, 2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_pend", bus.loads_pending, 0);
    check("flush_ready", bus.iss_ready, 1);
    respond(32'd1);
    check("drain1_err", bus.err_unexp, 0);
    tick();
    respond(32'd2);
    check("drain2_err", bus.err_unexp, 0);
    respond(32'd3);
    check("unexp_err", bus.err_unexp, 1);
    tick();

    // asynchronous reset mid-stream
    issue(2'd2, 5'd11, 32'd0);
    issue(2'd1, 5'd12, 32'd5);
    issue(2'd1, 5'd13, 32'd6);
    rst = 1'b1;
    #1;
    check("rst_ready", bus.iss_ready, 1);
    check("rst_we", bus.wb_we, 0);
    check("rst_alu", bus.wb_alu, 0);
    check("rst_src", bus.wb_src, 0);
    check("rst_pend", bus.loads_pending, 0);
    check("rst_err", bus.err_unexp, 0);
    tick();
    rst = 1'b0;
    tick();
    respond(32'h99);
    check("rst_abandon_err", bus.err_unexp, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bus.iss_valid     = ($urandom_range(0, 99) < 55);
      bus.iss_src       = 2'($urandom_range(0, 3));
      bus.iss_rd        = 5'($urandom_range(0, 31));
      bus.iss_nextPC    = $urandom;
      bus.iss_alu       = $urandom;
      bus.mem_rsp_data  = $urandom;
      if (m_pending() > 0 || m_drain > 0)
        bus.mem_rsp_valid = ($urandom_range(0, 99) < 40);
      else
        bus.mem_rsp_valid = (c > 3000) && ($urandom_range(0, 199) == 0);
      bus.flush         = ($urandom_range(0, 99) < 2);
      tick();
    end
    bus.iss_valid     = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.flush         = 1'b0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
